// File: rtl/prime_pkg.sv
// Shared types, sizing constants and the wide square compare used by the
// prime range generator and its trial-division step.
package prime_pkg;

    // Sequencer states of the range generator.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default and widest supported data width for bounds and primes.
    localparam int DEFAULT_W = 8;
    localparam int MAX_W     = 16;

    // True when d*d > cand. The square is formed at double width, so no
    // product bit is lost even at the widest supported data width.
    function automatic logic square_exceeds(input logic [MAX_W-1:0] d,
                                            input logic [MAX_W-1:0] cand);
        logic [2*MAX_W-1:0] d_ext_s;
        logic [2*MAX_W-1:0] sq_s;
        d_ext_s = {{MAX_W{1'b0}}, d};
        sq_s    = d_ext_s * d_ext_s;
        return (sq_s > {{MAX_W{1'b0}}, cand});
    endfunction

endpackage

// File: rtl/prime_trial_step.sv
// One trial-division step: does divisor d prove the candidate prime (d*d
// has passed the candidate) or prove it composite (d divides the candidate)?
module prime_trial_step
    import prime_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] cand,
    input  logic [W-1:0] d,
    output logic         is_prime_hit,
    output logic         is_divisible
);

    logic [MAX_W-1:0] cand_ext_s;
    logic [MAX_W-1:0] d_ext_s;

    assign cand_ext_s   = MAX_W'(cand);
    assign d_ext_s      = MAX_W'(d);
    assign is_prime_hit = square_exceeds(d_ext_s, cand_ext_s);
    // d is never zero while the result is consumed: each candidate starts at 2.
    assign is_divisible = ((cand % d) == {W{1'b0}});

endmodule

// File: rtl/prime_range_generator.sv
// Streams every prime in [lower, upper] in ascending order over a
// valid/ready port, testing one divisor per cycle by trial division.
module prime_range_generator
    import prime_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] lower,
    input  logic [W-1:0] upper,
    output logic         prime_valid,
    output logic [W-1:0] prime_data,
    input  logic         prime_ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] TWO_C  = {{(W-2){1'b0}}, 2'b10};

    state_t       state_r;
    logic [W-1:0] cand_r;
    logic [W-1:0] d_r;
    logic [W-1:0] upper_r;

    logic         is_prime_hit_s;
    logic         is_divisible_s;
    logic         empty_range_s;
    logic         at_upper_s;
    logic [W-1:0] first_cand_s;

    prime_trial_step #(.W(W)) u_trial_step (
        .cand         (cand_r),
        .d            (d_r),
        .is_prime_hit (is_prime_hit_s),
        .is_divisible (is_divisible_s)
    );

    assign empty_range_s = (upper < TWO_C) || (lower > upper);
    assign first_cand_s  = (lower < TWO_C) ? TWO_C : lower;
    // Compared before incrementing so an upper bound of all-ones never wraps.
    assign at_upper_s    = (cand_r == upper_r);

    // Sequencer, candidate/divisor datapath, handshake counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cand_r      <= ZERO_C;
            d_r         <= ZERO_C;
            upper_r     <= ZERO_C;
            prime_valid <= 1'b0;
            prime_data  <= ZERO_C;
            busy        <= 1'b0;
            done        <= 1'b0;
            count       <= ZERO_C;
        end else if (abort) begin
            // Cancel silently: no done pulse, count keeps completed handshakes.
            state_r     <= IDLE;
            prime_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        upper_r <= upper;
                        count   <= ZERO_C;
                        busy    <= 1'b1;
                        if (empty_range_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            cand_r  <= first_cand_s;
                            d_r     <= TWO_C;
                            state_r <= TEST;
                        end
                    end
                end
                TEST: begin
                    if (is_prime_hit_s) begin
                        state_r     <= EMIT;
                        prime_valid <= 1'b1;
                        prime_data  <= cand_r;
                    end else if (is_divisible_s) begin
                        if (at_upper_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            cand_r  <= cand_r + ONE_C;
                            d_r     <= TWO_C;
                        end
                    end else begin
                        d_r <= d_r + ONE_C;
                    end
                end
                EMIT: begin
                    if (prime_ready) begin
                        count       <= count + ONE_C;
                        prime_valid <= 1'b0;
                        if (at_upper_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            cand_r  <= cand_r + ONE_C;
                            d_r     <= TWO_C;
                            state_r <= TEST;
                        end
                    end else begin
                        prime_valid <= 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    prime_valid <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_range_generator.sv
// Directed self-checking bench for prime_range_generator (W = 8).
module tb_prime_range_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] lower;
    logic [7:0] upper;
    logic       prime_valid;
    logic [7:0] prime_data;
    logic       prime_ready;
    logic       busy;
    logic       done;
    logic [7:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int got_q[$];

    prime_range_generator #(.W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .lower       (lower),
        .upper       (upper),
        .prime_valid (prime_valid),
        .prime_data  (prime_data),
        .prime_ready (prime_ready),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic bit is_prime_ref(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++) if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Pulse start for one edge; returns at the falling edge after T0 (state T1).
    task automatic do_start(input logic [7:0] lo, input logic [7:0] hi);
        @(negedge clk);
        lower = lo; upper = hi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Record handshaken primes until done is seen; count stalled-output changes.
    task automatic collect(input int max_cycles, input int ready_pct,
                           output int stall_err, output bit timed_out);
        bit         prev_stall;
        logic [7:0] prev_data;
        got_q.delete();
        stall_err = 0; timed_out = 1'b1; prev_stall = 1'b0; prev_data = 8'd0;
        for (int c = 0; c < max_cycles; c++) begin
            if (prev_stall && (prime_valid !== 1'b1 || prime_data !== prev_data)) stall_err++;
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            prime_ready = (int'($urandom_range(99)) < ready_pct);
            if (prime_valid === 1'b1 && prime_ready) got_q.push_back(int'(prime_data));
            prev_stall = (prime_valid === 1'b1) && !prime_ready;
            prev_data  = prime_data;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({prime_valid, prime_data, busy, done, count} !== 19'd0) $display("FAIL reset_outputs: got %h expected 0", {prime_valid, prime_data, busy, done, count});
        else pass_cnt++;
    endtask

    task automatic test_first_prime_timing();
        prime_ready = 1'b1;
        do_start(8'd2, 8'd2);
        total_cnt++;
        if (busy !== 1'b1 || prime_valid !== 1'b0) $display("FAIL t1_state: got busy=%b valid=%b expected busy=1 valid=0", busy, prime_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (prime_valid !== 1'b1 || prime_data !== 8'd2) $display("FAIL t2_first_prime: got valid=%b data=%0d expected valid=1 data=2", prime_valid, prime_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b1 || count !== 8'd1) $display("FAIL single_done: got done=%b count=%0d expected done=1 count=1", done, count);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_full_small();
        int exp_q[$] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
        int serr; bit tout;
        do_start(8'd2, 8'd30);
        collect(1000, 100, serr, tout);
        total_cnt++;
        if (tout) $display("FAIL small_timeout: got no done expected done within 1000 cycles");
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() != exp_q.size()) $display("FAIL small_len: got %0d expected %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] != exp_q[i]) $display("FAIL small_prime[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (count !== 8'd10) $display("FAIL small_count: got %0d expected 10", count);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL small_after: got done=%b busy=%b expected 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_prime_gap();
        int serr; bit tout;
        do_start(8'd90, 8'd96);
        collect(500, 100, serr, tout);
        total_cnt++;
        if (tout || got_q.size() != 0 || count !== 8'd0) $display("FAIL gap: got timeout=%b primes=%0d count=%0d expected 0 0 0", tout, got_q.size(), count);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_empty_ranges();
        int serr; bit tout;
        do_start(8'd20, 8'd10);
        total_cnt++;
        if (done !== 1'b1 || count !== 8'd0) $display("FAIL empty_inverted: got done=%b count=%0d expected done=1 count=0", done, count);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL empty_after: got done=%b busy=%b expected 0 0", done, busy);
        else pass_cnt++;
        do_start(8'd0, 8'd1);
        total_cnt++;
        if (done !== 1'b1 || count !== 8'd0) $display("FAIL empty_upper1: got done=%b count=%0d expected done=1 count=0", done, count);
        else pass_cnt++;
        @(negedge clk);
        do_start(8'd0, 8'd2);
        collect(200, 100, serr, tout);
        total_cnt++;
        if (tout || got_q.size() != 1 || count !== 8'd1) $display("FAIL zero_to_two: got timeout=%b primes=%0d count=%0d expected 0 1 1", tout, got_q.size(), count);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() > 0 && got_q[0] != 2) $display("FAIL zero_to_two_val: got %0d expected 2", got_q[0]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int exp_q[$];
        int serr; bit tout; int bad;
        for (int n = 2; n <= 255; n++) if (is_prime_ref(n)) exp_q.push_back(n);
        do_start(8'd2, 8'd255);
        collect(6000, 30, serr, tout);
        total_cnt++;
        if (tout) $display("FAIL bp_timeout: got no done expected done within 6000 cycles");
        else pass_cnt++;
        total_cnt++;
        if (serr != 0) $display("FAIL bp_stall_stable: got %0d changes expected 0", serr);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() != 54) $display("FAIL bp_len: got %0d expected 54", got_q.size());
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] != 251) $display("FAIL bp_last: got %0d expected 251", (got_q.size() == 0) ? -1 : got_q[got_q.size()-1]);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] != exp_q[i]) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL bp_stream: got %0d wrong entries expected 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (count !== 8'd54) $display("FAIL bp_count: got %0d expected 54", count);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_full_range_time();
        int serr; bit tout;
        do_start(8'd2, 8'd255);
        collect(3000, 100, serr, tout);
        total_cnt++;
        if (tout || count !== 8'd54) $display("FAIL full_range_3000: got timeout=%b count=%0d expected 0 54", tout, count);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_abort_restart();
        bit found; bit saw_done; int serr; bit tout;
        prime_ready = 1'b1;
        do_start(8'd2, 8'd100);
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (prime_valid === 1'b1 && prime_data === 8'd13) begin
                prime_ready = 1'b0;
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (!found) $display("FAIL abort_reach13: got no 13 expected stalled 13");
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (prime_valid !== 1'b1 || prime_data !== 8'd13) $display("FAIL abort_stall: got valid=%b data=%0d expected 1 13", prime_valid, prime_data);
        else pass_cnt++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total_cnt++;
        if (prime_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 8'd5) $display("FAIL abort_effect: got valid=%b busy=%b done=%b count=%0d expected 0 0 0 5", prime_valid, busy, done, count);
        else pass_cnt++;
        saw_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done || count !== 8'd5) $display("FAIL abort_quiet: got done_seen=%b count=%0d expected 0 5", saw_done, count);
        else pass_cnt++;
        do_start(8'd97, 8'd97);
        collect(200, 100, serr, tout);
        total_cnt++;
        if (tout || got_q.size() != 1 || count !== 8'd1) $display("FAIL restart_97: got timeout=%b primes=%0d count=%0d expected 0 1 1", tout, got_q.size(), count);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() > 0 && got_q[0] != 97) $display("FAIL restart_97_val: got %0d expected 97", got_q[0]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int serr; bit tout;
        prime_ready = 1'b1;
        do_start(8'd2, 8'd255);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || count !== 8'd2) $display("FAIL pre_reset_run: got busy=%b count=%0d expected 1 2", busy, count);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({prime_valid, prime_data, busy, done, count} !== 19'd0) $display("FAIL async_reset: got %h expected 0", {prime_valid, prime_data, busy, done, count});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        do_start(8'd2, 8'd30);
        collect(1000, 100, serr, tout);
        total_cnt++;
        if (tout || got_q.size() != 10 || count !== 8'd10) $display("FAIL post_reset_run: got timeout=%b primes=%0d count=%0d expected 0 10 10", tout, got_q.size(), count);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() != 10 || got_q[9] != 29) $display("FAIL post_reset_last: got %0d expected 29", (got_q.size() == 0) ? -1 : got_q[got_q.size()-1]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; lower = 8'd0; upper = 8'd0; prime_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_first_prime_timing();
        test_full_small();
        test_prime_gap();
        test_empty_ranges();
        test_backpressure();
        test_full_range_time();
        test_abort_restart();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
